score_display_decoder: RTL and testbench
========================================

Name: score_display_decoder

Overview:
- Receive end of the scoreboard's time-multiplexed digit stream: watches the {segment_select, digit} pair driven to the display and reconstructs per-player scores, mode and win flags.
- Used as an on-chip monitor / loopback checker, and on a remote board that mirrors the scoreboard.
- Input stream: per player, a blinking player marker, then the tens symbol, then the ones symbol.
- Tennis mode shows a code on the tens position and blank (4'hF) on the ones position.

Parameters:
- STABLE_CYCLES, 16: consecutive identical samples before a symbol is accepted; minimum 2.
- WIN_TOGGLES, 12: accepted marker/blank symbols, with no tens symbol, that declare a win.
- TIMEOUT_W, 26: width of the no-symbol watchdog; it expires at 2^TIMEOUT_W-1 cycles.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- digit_i  in  4  displayed digit; 4'hF = blank
- segment_select_i  in  4  one-hot digit position; 4'b0001 = first (ones/marker), 4'b0010 = second (tens)
- p1_score_o  out  8  player-1 score: decimal 0..99, or tennis code
- p2_score_o  out  8  player-2 score, same encoding
- p1_tennis_o  out  1  player-1 score was received in tennis form
- p2_tennis_o  out  1  player-2 score was received in tennis form
- update_o  out  1  one-cycle pulse when a score is committed
- update_player_o  out  1  player of the last commit; 0 = P1, 1 = P2
- p1_win_o  out  1  player-1 win detected
- p2_win_o  out  1  player-2 win detected
- err_o  out  1  one-cycle pulse on a protocol violation
- link_o  out  1  a symbol has been accepted within the watchdog window

Behaviour:
- Reset: all outputs 0; FSM in HUNT; stabilizer history cleared.
- Stabilizer:
  - Samples {segment_select_i, digit_i} every cycle.
  - The run counter clears whenever the sample changes.
  - sym_stb pulses exactly once per run, on the cycle the counter reaches STABLE_CYCLES-1.
  - Runs shorter than STABLE_CYCLES are ignored.
  - Back-to-back identical runs merge into one symbol.
- Symbol classes:
  - MARK(p): seg 0001 with digit 1 or 2.
  - BLANK: seg 0001 with digit F.
  - TENS(d): seg 0010.
  - ONESD(d): seg 0001 with d<=9.
  - ONESB: seg 0001 with F.
  - Any other seg value = BAD.
  - Classification depends on state: seg 0001 is read as a ones symbol only in ONES_WAIT.
- FSM, all transitions on sym_stb only:
  - HUNT:
    - MARK(p): go to MARK; player=p; tog=1.
    - BLANK: stay.
    - Anything else: stay; no err.
  - MARK:
    - MARK(same p) or BLANK: tog+1 (saturating). When tog reaches WIN_TOGGLES: set pX_win_o, clear the other player's win, go to WIN.
    - MARK(other p): player=other; tog=1.
    - TENS(d): tens_r=d; go to ONES_WAIT.
    - BAD: err pulse; go to HUNT.
  - WIN:
    - MARK(same p) or BLANK: stay.
    - TENS(d): clear both win flags; tens_r=d; go to ONES_WAIT.
    - MARK(other p): clear win; go to MARK.
    - BAD: err; go to HUNT. Win flags hold.
  - ONES_WAIT:
    - ONESD(d) with tens_r<=9: score=tens_r*10+d (8-bit, max 99); tennis=0; commit.
    - ONESB: score={4'h0,tens_r}; tennis=1; commit.
    - ONESD with tens_r>9, digit A..E on seg 0001, TENS, or BAD: err pulse; no commit.
    - All cases: go to HUNT.
- Commit:
  - Registered; the score/tennis registers and update_o/update_player_o all change on the cycle after sym_stb.
  - Only the addressed player's registers change.
- Watchdog:
  - Counter clears on every sym_stb and saturates.
  - At saturation: link_o=0 and FSM forced to HUNT. Scores and win flags hold.
  - link_o=1 on the cycle after any sym_stb.
- Simultaneous events: a watchdog expiry in the same cycle as sym_stb is ignored; sym_stb wins.
- Reset mid-frame: the partial frame is discarded; no update pulse.

Decomposition:
- Package score_display_pkg:
  - SEG_FIRST=4'b0001, SEG_SECOND=4'b0010, DIGIT_BLANK=4'hF.
  - Marker digit constants.
  - FSM state encoding: HUNT, MARK, WIN, ONES_WAIT.
  - Symbol-class encoding.
- Sub-module symbol_stabilizer: run-length filter producing sym_stb plus the held seg/digit pair.

Test Plan (STABLE_CYCLES=4, WIN_TOGGLES=6, TIMEOUT_W=8):
- Decimal frame: 1,F,1,F,1 on seg0001; 4 on seg0010; 2 on seg0001; 8 cycles each -> one update_o, p1_score_o=42, p1_tennis_o=0, update_player_o=0.
- Tennis P2: 2,F,2 markers; 3 on seg0010; F on seg0001 -> p2_score_o=3, p2_tennis_o=1, p1 registers unchanged.
- Glitch: a 3-cycle pulse of digit 7 inside the tens run -> ignored; score still 42.
- Win: P1 marker/blank alternating 6 symbols with no tens -> p1_win_o=1. A later TENS 0, ONES 0 -> p1_win_o=0, p1_score_o=0.
- Errors: ones digit C after tens 5 -> err_o pulse, no update. Seg 0100 while in MARK -> err_o, FSM back to HUNT.
- Watchdog and reset: inputs frozen for 300 cycles -> link_o=0, scores held. Async rst_i during ONES_WAIT -> all outputs 0, no update_o.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared constants, state/symbol encodings and decode helpers for the
// scoreboard digit-stream receiver.
package score_display_pkg;

    localparam logic [3:0] SEG_FIRST     = 4'b0001;
    localparam logic [3:0] SEG_SECOND    = 4'b0010;
    localparam logic [3:0] DIGIT_BLANK   = 4'hF;
    localparam logic [3:0] DIGIT_MARK_P1 = 4'd1;
    localparam logic [3:0] DIGIT_MARK_P2 = 4'd2;

    typedef enum logic [1:0] {
        HUNT,
        MARK,
        WIN,
        ONES_WAIT
    } dec_state_e;

    typedef enum logic [2:0] {
        SYM_BAD,
        SYM_MARK1,
        SYM_MARK2,
        SYM_BLANK,
        SYM_TENS,
        SYM_ONESD,
        SYM_ONESB
    } sym_class_e;

    // The first position carries markers everywhere except while waiting for
    // the ones digit, where it carries the ones symbol instead.
    function automatic sym_class_e classify_symbol(input logic [3:0] seg,
                                                   input logic [3:0] digit,
                                                   input logic       ones_ctx);
        sym_class_e c;
        c = SYM_BAD;
        if (seg == SEG_SECOND) begin
            c = SYM_TENS;
        end else if (seg == SEG_FIRST) begin
            if (ones_ctx) begin
                if (digit == DIGIT_BLANK)
                    c = SYM_ONESB;
                else if (digit <= 4'd9)
                    c = SYM_ONESD;
            end else begin
                if (digit == DIGIT_MARK_P1)
                    c = SYM_MARK1;
                else if (digit == DIGIT_MARK_P2)
                    c = SYM_MARK2;
                else if (digit == DIGIT_BLANK)
                    c = SYM_BLANK;
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] decimal_score(input logic [3:0] tens,
                                                 input logic [3:0] ones);
        logic [7:0] t;
        t = {4'h0, tens};
        return (t << 3) + (t << 1) + {4'h0, ones};
    endfunction

endpackage

// File: rtl/score_display_decoder_stabilizer.sv
// Run-length filter: a {seg, digit} pair must hold for STABLE_CYCLES samples
// before it is presented once as a symbol.
module symbol_stabilizer #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] seg,
    input  logic [3:0] digit,
    output logic       sym_stb,
    output logic [3:0] sym_seg,
    output logic [3:0] sym_digit
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] run_cnt;
    logic             same;

    assign same = ({seg, digit} == {sym_seg, sym_digit});

    // The counter parks at CNT_LAST so a long run strobes only once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sym_seg   <= '0;
            sym_digit <= '0;
            run_cnt   <= '0;
            sym_stb   <= 1'b0;
        end else begin
            sym_stb <= same && (run_cnt == CNT_LAST - 1'b1);
            if (!same) begin
                sym_seg   <= seg;
                sym_digit <= digit;
                run_cnt   <= '0;
            end else if (run_cnt != CNT_LAST) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_display_decoder.sv
// Rebuilds per-player scores, tennis flags and win flags from the
// time-multiplexed {segment_select, digit} stream driven to the display.
module score_display_decoder
    import score_display_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int WIN_TOGGLES   = 12,
    parameter int TIMEOUT_W     = 26
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] digit_i,
    input  logic [3:0] segment_select_i,
    output logic [7:0] p1_score_o,
    output logic [7:0] p2_score_o,
    output logic       p1_tennis_o,
    output logic       p2_tennis_o,
    output logic       update_o,
    output logic       update_player_o,
    output logic       p1_win_o,
    output logic       p2_win_o,
    output logic       err_o,
    output logic       link_o
);

    localparam int TOG_W = $clog2(WIN_TOGGLES + 1);

    logic           sym_stb;
    logic [3:0]     sym_seg;
    logic [3:0]     sym_digit;
    dec_state_e     state;
    sym_class_e     cls;
    logic           player;
    logic [TOG_W-1:0] tog;
    logic [3:0]     tens;
    logic [TIMEOUT_W-1:0] wd;
    logic           is_mark;
    logic           mark_p;

    symbol_stabilizer #(.STABLE_CYCLES(STABLE_CYCLES)) u_stab (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .seg       (segment_select_i),
        .digit     (digit_i),
        .sym_stb   (sym_stb),
        .sym_seg   (sym_seg),
        .sym_digit (sym_digit)
    );

    assign cls     = classify_symbol(sym_seg, sym_digit, state == ONES_WAIT);
    assign is_mark = (cls == SYM_MARK1) || (cls == SYM_MARK2);
    assign mark_p  = (cls == SYM_MARK2);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= HUNT;
            player          <= 1'b0;
            tog             <= '0;
            tens            <= '0;
            wd              <= '0;
            p1_score_o      <= '0;
            p2_score_o      <= '0;
            p1_tennis_o     <= 1'b0;
            p2_tennis_o     <= 1'b0;
            update_o        <= 1'b0;
            update_player_o <= 1'b0;
            p1_win_o        <= 1'b0;
            p2_win_o        <= 1'b0;
            err_o           <= 1'b0;
            link_o          <= 1'b0;
        end else begin
            update_o <= 1'b0;
            err_o    <= 1'b0;
            if (sym_stb) begin
                wd     <= '0;
                link_o <= 1'b1;
                case (state)
                    HUNT: begin
                        if (is_mark) begin
                            state  <= MARK;
                            player <= mark_p;
                            tog    <= TOG_W'(1);
                        end
                    end
                    MARK: begin
                        if (cls == SYM_BLANK || (is_mark && mark_p == player)) begin
                            if (tog >= TOG_W'(WIN_TOGGLES - 1)) begin
                                state    <= WIN;
                                tog      <= TOG_W'(WIN_TOGGLES);
                                p1_win_o <= !player;
                                p2_win_o <= player;
                            end else begin
                                tog <= tog + 1'b1;
                            end
                        end else if (is_mark) begin
                            player <= mark_p;
                            tog    <= TOG_W'(1);
                        end else if (cls == SYM_TENS) begin
                            tens  <= sym_digit;
                            state <= ONES_WAIT;
                        end else begin
                            err_o <= 1'b1;
                            state <= HUNT;
                        end
                    end
                    WIN: begin
                        if (is_mark && mark_p != player) begin
                            p1_win_o <= 1'b0;
                            p2_win_o <= 1'b0;
                            player   <= mark_p;
                            tog      <= TOG_W'(1);
                            state    <= MARK;
                        end else if (cls == SYM_TENS) begin
                            p1_win_o <= 1'b0;
                            p2_win_o <= 1'b0;
                            tens     <= sym_digit;
                            state    <= ONES_WAIT;
                        end else if (cls == SYM_BAD) begin
                            err_o <= 1'b1;
                            state <= HUNT;
                        end
                    end
                    ONES_WAIT: begin
                        state <= HUNT;
                        // Decimal needs a 0..9 tens digit; blank ones marks a tennis code.
                        if ((cls == SYM_ONESD && tens <= 4'd9) || cls == SYM_ONESB) begin
                            update_o        <= 1'b1;
                            update_player_o <= player;
                            if (player) begin
                                p2_score_o  <= (cls == SYM_ONESB) ? {4'h0, tens}
                                                                  : decimal_score(tens, sym_digit);
                                p2_tennis_o <= (cls == SYM_ONESB);
                            end else begin
                                p1_score_o  <= (cls == SYM_ONESB) ? {4'h0, tens}
                                                                  : decimal_score(tens, sym_digit);
                                p1_tennis_o <= (cls == SYM_ONESB);
                            end
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end else if (&wd) begin
                link_o <= 1'b0;
                state  <= HUNT;
            end else begin
                wd <= wd + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_score_display_decoder.sv
// Directed stimulus with a scoreboard queue of expected update/error events
// and a monitor that pops and compares whenever the decoder reports one.
module tb_score_display_decoder;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] digit_i;
    logic [3:0] segment_select_i;
    logic [7:0] p1_score_o, p2_score_o;
    logic       p1_tennis_o, p2_tennis_o;
    logic       update_o, update_player_o;
    logic       p1_win_o, p2_win_o, err_o, link_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_err;
        bit         player;
        logic [7:0] score;
        bit         tennis;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    score_display_decoder #(
        .STABLE_CYCLES(4),
        .WIN_TOGGLES  (6),
        .TIMEOUT_W    (8)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .digit_i         (digit_i),
        .segment_select_i(segment_select_i),
        .p1_score_o      (p1_score_o),
        .p2_score_o      (p2_score_o),
        .p1_tennis_o     (p1_tennis_o),
        .p2_tennis_o     (p2_tennis_o),
        .update_o        (update_o),
        .update_player_o (update_player_o),
        .p1_win_o        (p1_win_o),
        .p2_win_o        (p2_win_o),
        .err_o           (err_o),
        .link_o          (link_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [3:0] seg, input logic [3:0] d, input int n);
        segment_select_i = seg;
        digit_i          = d;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic expect_upd(input bit p, input logic [7:0] s, input bit t);
        exp_t e;
        e.is_err = 1'b0; e.player = p; e.score = s; e.tennis = t;
        sb.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1; e.player = 1'b0; e.score = '0; e.tennis = 1'b0;
        sb.push_back(e);
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && (update_o || err_o)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: update=%0b err=%0b expected no event at %0t",
                         update_o, err_o, $time);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_err) begin
                    chk("err_pulse", {30'd0, update_o, err_o}, 32'd1);
                end else begin
                    chk("upd_pulse", {30'd0, update_o, err_o}, 32'd2);
                    chk("upd_player", update_player_o, mon_e.player);
                    chk("upd_score", mon_e.player ? p2_score_o : p1_score_o, mon_e.score);
                    chk("upd_tennis", mon_e.player ? p2_tennis_o : p1_tennis_o, mon_e.tennis);
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        segment_select_i = 4'b0000;
        digit_i = 4'h0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_outputs", {p1_score_o, p2_score_o, p1_tennis_o, p2_tennis_o, update_o,
                            update_player_o, p1_win_o, p2_win_o, err_o, link_o}, 32'd0);
        rst_i = 1'b0;
        send(4'b0000, 4'h0, 8);

        // Decimal frame for P1: 42
        send(4'b0001, 4'h1, 8); send(4'b0001, 4'hF, 8);
        send(4'b0001, 4'h1, 8); send(4'b0001, 4'hF, 8);
        send(4'b0001, 4'h1, 8);
        send(4'b0010, 4'h4, 8);
        expect_upd(1'b0, 8'd42, 1'b0);
        send(4'b0001, 4'h2, 8);
        chk("p1_score_42", p1_score_o, 8'd42);
        chk("p1_tennis_0", p1_tennis_o, 1'b0);

        // Tennis frame for P2: code 3
        send(4'b0001, 4'h2, 8); send(4'b0001, 4'hF, 8); send(4'b0001, 4'h2, 8);
        send(4'b0010, 4'h3, 8);
        expect_upd(1'b1, 8'd3, 1'b1);
        send(4'b0001, 4'hF, 8);
        chk("p2_score_3", p2_score_o, 8'd3);
        chk("p2_tennis_1", p2_tennis_o, 1'b1);
        chk("p1_held_score", p1_score_o, 8'd42);
        chk("p1_held_tennis", p1_tennis_o, 1'b0);

        // Short glitch inside the tens run is filtered
        send(4'b0001, 4'h1, 8);
        send(4'b0010, 4'h4, 2); send(4'b0010, 4'h7, 3); send(4'b0010, 4'h4, 8);
        expect_upd(1'b0, 8'd42, 1'b0);
        send(4'b0001, 4'h2, 8);
        chk("glitch_score", p1_score_o, 8'd42);

        // P1 win after six marker/blank symbols, cleared by the next score
        for (int i = 0; i < 3; i++) begin
            send(4'b0001, 4'h1, 8);
            if (i < 2) chk("no_early_win", p1_win_o, 1'b0);
            send(4'b0001, 4'hF, 8);
        end
        chk("p1_win_set", p1_win_o, 1'b1);
        chk("p2_win_clear", p2_win_o, 1'b0);
        send(4'b0010, 4'h0, 8);
        expect_upd(1'b0, 8'd0, 1'b0);
        send(4'b0001, 4'h0, 8);
        chk("p1_win_cleared", p1_win_o, 1'b0);
        chk("p1_score_0", p1_score_o, 8'd0);

        // Ones digit C after tens 5 is an error with no commit
        send(4'b0001, 4'h1, 8); send(4'b0010, 4'h5, 8);
        expect_err();
        send(4'b0001, 4'hC, 8);
        chk("err_no_commit", p1_score_o, 8'd0);

        // Illegal segment while in MARK drops back to HUNT
        send(4'b0001, 4'h2, 8);
        expect_err();
        send(4'b0100, 4'h3, 8);
        send(4'b0010, 4'h6, 8);
        send(4'b0001, 4'h2, 8); send(4'b0010, 4'h7, 8);
        expect_upd(1'b1, 8'd75, 1'b0);
        send(4'b0001, 4'h5, 8);
        chk("p2_score_75", p2_score_o, 8'd75);
        chk("link_up", link_o, 1'b1);

        // Frozen input: watchdog drops the link, scores hold
        repeat (300) @(posedge clk_i);
        #1;
        chk("link_down", link_o, 1'b0);
        chk("wd_p1_held", p1_score_o, 8'd0);
        chk("wd_p2_held", p2_score_o, 8'd75);
        chk("wd_p2_tennis_held", p2_tennis_o, 1'b0);
        send(4'b0001, 4'h1, 8);
        chk("link_back", link_o, 1'b1);

        // Asynchronous reset while waiting for the ones digit
        send(4'b0010, 4'h9, 8);
        #3 rst_i = 1'b1;
        #1;
        chk("async_rst_outputs", {p1_score_o, p2_score_o, p1_tennis_o, p2_tennis_o, update_o,
                                  update_player_o, p1_win_o, p2_win_o, err_o, link_o}, 32'd0);
        segment_select_i = 4'b0001;
        digit_i = 4'h3;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        chk("post_rst_p1", p1_score_o, 8'd0);
        chk("post_rst_p2", p2_score_o, 8'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
